// File: rtl/stream_serializer_pkg.sv
// Shared types and sizing helpers for the stream serializer.
package stream_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/stream_serializer_parity.sv
// Parity of a payload word: XOR of all bits, inverted for odd parity.
module serializer_parity #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = (^data_i) ^ (PARITY_ODD != 0);

endmodule

// File: rtl/stream_serializer.sv
// Parallel-to-serial framer: start bit, payload, optional parity, guard bits,
// with a one-word holding register so back-to-back frames have no idle gap.
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              d_out,
  output logic              frame_active,
  output logic              frame_done
);

  localparam int              CNT_W     = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'((STOP_BITS > 0) ? STOP_BITS - 1 : 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0]  load_word;
  logic               hold_vld_q, hold_vld_d;
  logic               par_q, par_d, load_par;
  logic               d_out_q, d_out_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               accept, go_next;

  // True when (st, cnt) describes the final bit cycle of a frame.
  function automatic logic is_last(input state_e st, input logic [CNT_W-1:0] cnt);
    case (st)
      ST_DATA:   return (cnt == DATA_LAST) && (PARITY_EN == 0) && (STOP_BITS == 0);
      ST_PARITY: return (STOP_BITS == 0);
      ST_STOP:   return (cnt == STOP_LAST);
      default:   return 1'b0;
    endcase
  endfunction

  assign in_ready  = ~hold_vld_q & ~flush;
  assign accept    = in_valid & in_ready;
  assign load_word = hold_vld_q ? hold_q : in_data;
  assign go_next   = (state_q == ST_IDLE) || is_last(state_q, cnt_q);

  serializer_parity #(
    .DATA_W    (DATA_W),
    .PARITY_ODD(PARITY_ODD)
  ) u_parity (
    .data_i  (load_word),
    .parity_o(load_par)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;

    case (state_q)
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
        if (cnt_q == DATA_LAST) begin
          cnt_d = '0;
          if (PARITY_EN != 0)      state_d = ST_PARITY;
          else if (STOP_BITS != 0) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (STOP_BITS != 0) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end
      end
      ST_STOP: cnt_d = cnt_q + CNT_W'(1);
      default: ;
    endcase

    // Frame boundary: a buffered word wins, else a word offered right now.
    if (go_next) begin
      cnt_d = '0;
      if (hold_vld_q || accept) begin
        state_d    = ST_START;
        shift_d    = load_word;
        par_d      = load_par;
        hold_vld_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (accept) begin
      hold_d     = in_data;
      hold_vld_d = 1'b1;
    end

    if (flush) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      hold_vld_d = 1'b0;
    end
  end

  // Line outputs are registered from the next state so they align with it.
  always_comb begin
    d_out_d  = 1'b0;
    active_d = 1'b0;
    done_d   = is_last(state_d, cnt_d);
    case (state_d)
      ST_START: begin
        d_out_d  = 1'b1;
        active_d = 1'b1;
      end
      ST_DATA: begin
        d_out_d  = (MSB_FIRST != 0) ? shift_d[DATA_W-1] : shift_d[0];
        active_d = 1'b1;
      end
      ST_PARITY: begin
        d_out_d  = par_d;
        active_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hold_vld_q <= 1'b0;
      d_out_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_vld_q <= hold_vld_d;
      d_out_q    <= d_out_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
    par_q   <= par_d;
  end

  assign d_out        = d_out_q;
  assign frame_active = active_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: three parameter variants share one stimulus
// stream and are each compared against a frame-level reference model.
module tb_stream_serializer;

  localparam int N = 3;
  localparam int MSBF  [N] = '{1, 0, 0};
  localparam int PEN   [N] = '{1, 0, 1};
  localparam int PODD  [N] = '{0, 0, 1};
  localparam int STOPB [N] = '{1, 0, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [N-1:0] rdy, dout, act, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the frame currently on the line plus at most one waiting word.
  logic [15:0] m_d  [N];
  logic [15:0] m_a  [N];
  logic [15:0] m_dn [N];
  int          m_pos [N];
  int          m_len [N];
  logic        m_pv  [N];
  logic [7:0]  m_pw  [N];

  always #5 clk = ~clk;

  stream_serializer #(.DATA_W(8), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .d_out(dout[0]), .frame_active(act[0]), .frame_done(done[0]));

  stream_serializer #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .d_out(dout[1]), .frame_active(act[1]), .frame_done(done[1]));

  stream_serializer #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[2]), .d_out(dout[2]), .frame_active(act[2]), .frame_done(done[2]));

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s u%0d: observed 'h%0h expected 'h%0h", tag, inst, obs, exp);
    end
  endtask

  function automatic void load_frame(input int i, input logic [7:0] w);
    int n;
    n = 0;
    m_d[i] = '0; m_a[i] = '0; m_dn[i] = '0;
    m_d[i][n] = 1'b1; m_a[i][n] = 1'b1; n++;
    for (int k = 0; k < 8; k++) begin
      m_d[i][n] = (MSBF[i] != 0) ? w[7-k] : w[k];
      m_a[i][n] = 1'b1;
      n++;
    end
    if (PEN[i] != 0) begin
      m_d[i][n] = (^w) ^ (PODD[i] != 0);
      m_a[i][n] = 1'b1;
      n++;
    end
    n += STOPB[i];
    m_dn[i][n-1] = 1'b1;
    m_len[i] = n;
    m_pos[i] = 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_len[i] = 0; m_pos[i] = 0; m_pv[i] = 1'b0; m_pw[i] = 8'h00;
      m_d[i] = '0; m_a[i] = '0; m_dn[i] = '0;
    end
  endfunction

  function automatic void model_edge(input int i, input logic acc, input logic fl, input logic [7:0] dat);
    logic taken;
    taken = 1'b0;
    if (fl) begin
      m_len[i] = 0; m_pos[i] = 0; m_pv[i] = 1'b0;
    end else begin
      if (m_pos[i] < m_len[i]) m_pos[i]++;
      if (m_pos[i] >= m_len[i]) begin
        if (m_pv[i]) begin
          m_pv[i] = 1'b0;
          load_frame(i, m_pw[i]);
        end else if (acc) begin
          load_frame(i, dat);
          taken = 1'b1;
        end else begin
          m_len[i] = 0; m_pos[i] = 0;
        end
      end
      if (acc && !taken) begin
        m_pv[i] = 1'b1;
        m_pw[i] = dat;
      end
    end
  endfunction

  // One clock cycle: check readiness, clock the edge, check the line.
  task automatic tick();
    logic       fl_s;
    logic [7:0] dat_s;
    logic       acc_l [N];
    #1;
    fl_s  = flush;
    dat_s = in_data;
    for (int i = 0; i < N; i++) begin
      chk("in_ready", i, 32'(rdy[i]), 32'(!m_pv[i] && !fl_s));
      acc_l[i] = in_valid && !m_pv[i] && !fl_s;
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) model_edge(i, acc_l[i], fl_s, dat_s);
    #1;
    for (int i = 0; i < N; i++) begin
      logic cur;
      cur = (m_pos[i] < m_len[i]);
      chk("d_out", i, 32'(dout[i]), 32'(cur ? m_d[i][m_pos[i]] : 1'b0));
      chk("frame_active", i, 32'(act[i]), 32'(cur ? m_a[i][m_pos[i]] : 1'b0));
      chk("frame_done", i, 32'(done[i]), 32'(cur ? m_dn[i][m_pos[i]] : 1'b0));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [10:0] seq, dseq;
    logic [9:0]  s1, a1;
    logic [21:0] bb, db;
    logic [11:0] rb;
    int nh, nd;

    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_d_out", i, 32'(dout[i]), 32'(0));
      chk("rst_active", i, 32'(act[i]), 32'(0));
      chk("rst_done", i, 32'(done[i]), 32'(0));
      chk("rst_ready", i, 32'(rdy[i]), 32'(1));
    end

    // Single frame 0xA5, MSB first with even parity and one guard bit.
    in_valid = 1'b1; in_data = 8'hA5; tick(); in_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) tick();
      seq[10-c]  = dout[0];
      dseq[10-c] = done[0];
    end
    chk("a5_line", 0, 32'(seq), 32'(11'b11010010100));
    chk("a5_done", 0, 32'(dseq), 32'(11'b00000000001));
    idle(4);

    // LSB first, no parity, no guard bits.
    in_valid = 1'b1; in_data = 8'h01; tick(); in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      s1[9-c] = dout[1];
      a1[9-c] = act[1];
    end
    chk("lsb_line", 1, 32'(s1), 32'(10'b1100000000));
    chk("lsb_active", 1, 32'(a1), 32'(10'b1111111110));
    idle(4);

    // Odd parity on the LSB-first variant: parity bit sits at frame position 9.
    in_valid = 1'b1; in_data = 8'hFF; tick(); in_valid = 1'b0;
    repeat (9) tick();
    chk("odd_par_ff", 2, 32'(dout[2]), 32'(1));
    idle(4);
    in_valid = 1'b1; in_data = 8'h7F; tick(); in_valid = 1'b0;
    repeat (9) tick();
    chk("odd_par_7f", 2, 32'(dout[2]), 32'(0));
    idle(4);

    // Back-to-back 0x3C then 0xC3 with in_valid held high.
    in_valid = 1'b1; in_data = 8'h3C; tick(); in_data = 8'hC3;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) tick();
      bb[21-c] = dout[0];
      db[21-c] = done[0];
      if (c < 12) rb[11-c] = rdy[0];
      if (c == 11) in_valid = 1'b0;
    end
    chk("b2b_line", 0, 32'(bb), 32'({11'b10011110000, 11'b11100001100}));
    chk("b2b_done", 0, 32'(db), 32'({11'b00000000001, 11'b00000000001}));
    chk("b2b_ready", 0, 32'(rb), 32'(12'b100000000001));
    idle(30);

    // Flush during payload bit 4 with a word buffered.
    in_valid = 1'b1; in_data = 8'h96; tick(); in_data = 8'h5A; tick(); in_valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    #1;
    for (int i = 0; i < N; i++) chk("flush_ready_low", i, 32'(rdy[i]), 32'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_line", 0, 32'(dout[0]), 32'(0));
    chk("flush_ready_back", 0, 32'(rdy[0]), 32'(1));
    nh = 0; nd = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      nh += int'(dout[0]);
      nd += int'(done[0]);
    end
    chk("flush_quiet_line", 0, 32'(nh), 32'(0));
    chk("flush_no_done", 0, 32'(nd), 32'(0));

    // Asynchronous reset mid-frame, then a clean frame right after release.
    in_valid = 1'b1; in_data = 8'h5A; tick(); in_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("arst_d_out", i, 32'(dout[i]), 32'(0));
      chk("arst_active", i, 32'(act[i]), 32'(0));
      chk("arst_done", i, 32'(done[i]), 32'(0));
    end
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A; tick(); in_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) tick();
      seq[10-c] = dout[0];
    end
    chk("post_rst_line", 0, 32'(seq), 32'(11'b10101101000));
    idle(4);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_data  = 8'($urandom);
      flush    = ($urandom_range(0, 99) < 3);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
